// File: rtl/fpu_issue_if.sv
// fpu_issue_if: request, unit and result channels of the FPU issue stage.
// The slave modport is the issue block; the master modport is its environment
// (requester, arithmetic unit and result consumer).
`timescale 1ns/1ps
interface fpu_issue_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  req_op;
   logic        dispatch;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  op;
   logic        done;
   logic [31:0] q;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_q;
   logic [1:0]  res_op;
   logic        res_err;

   modport slave (
      input  req_valid, req_a, req_b, req_op, done, q, res_ready,
      output req_ready, dispatch, a, b, op, res_valid, res_q, res_op, res_err
   );

   modport master (
      output req_valid, req_a, req_b, req_op, done, q, res_ready,
      input  req_ready, dispatch, a, b, op, res_valid, res_q, res_op, res_err
   );
endinterface

// File: rtl/fpu_issue.sv
// fpu_issue: queues FPU requests, issues them one at a time to a multi-cycle
// unit and returns results in order through a single result register.
// Optional watchdog: define FPU_ISSUE_TIMEOUT_EN to complete a stuck operation
// after TIMEOUT wait cycles with a quiet NaN and res_err set.
`timescale 1ns/1ps
module fpu_issue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input logic        clk,
   input logic        rst_n,
   fpu_issue_if.slave bus
);
   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
      $error("fpu_issue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [31:0]   mem_a  [DEPTH];
   logic [31:0]   mem_b  [DEPTH];
   logic [1:0]    mem_op [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;

   logic [31:0] a_r;
   logic [31:0] b_r;
   logic [1:0]  op_r;
   logic        res_valid_r;
   logic [31:0] res_q_r;
   logic [1:0]  res_op_r;

   logic push;
   logic pop;
   logic accept;
   logic expired;

   // The queue refuses requests while reset is held so nothing is lost.
   assign bus.req_ready = rst_n & (count < FULL);
   assign push          = bus.req_valid & bus.req_ready;
   // Only issue when the result slot is free now or is being freed this cycle.
   assign pop           = (state == IDLE) && (count != '0) && (!res_valid_r || bus.res_ready);
   assign accept        = (state == WAIT) && bus.done;

   assign bus.dispatch  = (state == ISSUE);
   assign bus.a         = a_r;
   assign bus.b         = b_r;
   assign bus.op        = op_r;
   assign bus.res_valid = res_valid_r;
   assign bus.res_q     = res_q_r;
   assign bus.res_op    = res_op_r;

`ifdef FPU_ISSUE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wait_cnt;
   logic          res_err_r;

   // A missing done on the last allowed wait cycle ends the operation.
   assign expired     = (state == WAIT) && !bus.done && (wait_cnt == TW'(TIMEOUT - 1));
   assign bus.res_err = res_err_r;

   // Wait-cycle counter: restarts on every issue, counts while waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == ISSUE) begin
         wait_cnt <= '0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + TW'(1);
      end
   end

   // Error flag travels with the result it describes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_err_r <= 1'b0;
      end else if (accept) begin
         res_err_r <= 1'b0;
      end else if (expired) begin
         res_err_r <= 1'b1;
      end
   end
`else
   assign expired     = 1'b0;
   assign bus.res_err = 1'b0;
`endif

   // Queue storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]  <= bus.req_a;
         mem_b[wr_ptr]  <= bus.req_b;
         mem_op[wr_ptr] <= bus.req_op;
      end
   end

   // Queue pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: ;
         endcase
      end
   end

   // Operands are captured as the head leaves the queue and held until completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r  <= '0;
         b_r  <= '0;
         op_r <= '0;
      end else if (pop) begin
         a_r  <= mem_a[rd_ptr];
         b_r  <= mem_b[rd_ptr];
         op_r <= mem_op[rd_ptr];
      end
   end

   // Result register: loaded on completion, emptied when the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_r <= 1'b0;
         res_q_r     <= '0;
         res_op_r    <= '0;
      end else if (accept) begin
         res_valid_r <= 1'b1;
         res_q_r     <= bus.q;
         res_op_r    <= op_r;
      end else if (expired) begin
         res_valid_r <= 1'b1;
         res_q_r     <= 32'h7fc0_0000;
         res_op_r    <= op_r;
      end else if (res_valid_r && bus.res_ready) begin
         res_valid_r <= 1'b0;
      end
   end

   // Issue state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Issue sequencing: one start cycle, then wait for the unit (or the watchdog).
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pop) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (accept || expired) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: self-checking bench for fpu_issue with a model divide unit,
// request/result scoreboards and table-driven operand vectors.
`timescale 1ns/1ps
module tb_fpu_issue;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] exp_q;
      logic        exp_err;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int pass_cnt   = 0;
   int total_cnt  = 0;
   int cyc        = 0;
   int last_disp  = -100;
   int disp_count = 0;

   vec_t vecs [5];
   vec_t res_sb [$];
   vec_t iss_q [$];
   vec_t mon_e;

   logic        unit_manual = 1'b1;
   logic        manual_done = 1'b0;
   logic [31:0] manual_q    = 32'h0;
   logic        model_done  = 1'b0;
   logic [31:0] model_q     = 32'h0;
   int          model_cnt   = 0;
   logic [31:0] ua = 32'h0;
   logic [31:0] ub = 32'h0;

   fpu_issue_if bus ();

   fpu_issue #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign bus.done = unit_manual ? manual_done : model_done;
   assign bus.q    = unit_manual ? manual_q    : model_q;

   function automatic logic [31:0] divModel(input logic [31:0] x, input logic [31:0] y);
      case ({x, y})
         {32'h3f800000, 32'h3f800000}: return 32'h3f800000;
         {32'h40490fdb, 32'h402df854}: return 32'h3f93eee0;
         {32'h402df854, 32'h40490fdb}: return 32'h3f5d816a;
         {32'h3f800000, 32'h3f000000}: return 32'h40000000;
         default:                      return 32'h0bad0bad;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Model unit: raises done for one cycle, three cycles after each dispatch.
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         model_cnt  = 0;
         model_done = 1'b0;
      end else if (bus.dispatch) begin
         ua         = bus.a;
         ub         = bus.b;
         model_cnt  = 3;
         model_done = 1'b0;
      end else if (model_cnt > 0) begin
         model_cnt--;
         model_done = (model_cnt == 0);
         if (model_cnt == 0) model_q = divModel(ua, ub);
      end else begin
         model_done = 1'b0;
      end
   end

   // Monitor: dispatch spacing and operands, plus in-order result scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.dispatch) begin
            checkOutput("dispatch_gap_ok", 32'(cyc - last_disp >= 3), 32'd1);
            last_disp = cyc;
            disp_count++;
            checkOutput("dispatch_expected", 32'(iss_q.size() != 0), 32'd1);
            if (iss_q.size() != 0) begin
               mon_e = iss_q.pop_front();
               checkOutput("dispatch_a", bus.a, mon_e.a);
               checkOutput("dispatch_b", bus.b, mon_e.b);
               checkOutput("dispatch_op", 32'(bus.op), 32'(mon_e.op));
            end
         end
         if (bus.res_valid && bus.res_ready) begin
            checkOutput("result_expected", 32'(res_sb.size() != 0), 32'd1);
            if (res_sb.size() != 0) begin
               mon_e = res_sb.pop_front();
               checkOutput("res_q", bus.res_q, mon_e.exp_q);
               checkOutput("res_op", 32'(bus.res_op), 32'(mon_e.op));
               checkOutput("res_err", 32'(bus.res_err), 32'(mon_e.exp_err));
            end
         end
      end
   end

   task automatic applyStimulus(input vec_t v);
      bit taken = 1'b0;
      bus.req_a     = v.a;
      bus.req_b     = v.b;
      bus.req_op    = v.op;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 50 && !taken; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            taken = 1'b1;
            res_sb.push_back(v);
            iss_q.push_back(v);
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      checkOutput("req_accepted", 32'(taken), 32'd1);
   endtask

   task automatic waitSignal(input string name, input int which, input int budget, output int at);
      bit hit = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if ((which == 0 && bus.dispatch) || (which == 1 && bus.res_valid)) begin
            hit = 1'b1;
            at  = cyc;
         end
      end
      checkOutput(name, 32'(hit), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input string name, input int budget);
      bit empty = 1'b0;
      for (int i = 0; i < budget && !empty; i++) begin
         @(negedge clk);
         #1;
         empty = (res_sb.size() == 0) && (iss_q.size() == 0);
      end
      checkOutput(name, 32'(empty), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   d0;
      int   t_disp;
      int   t_res;
      bit   ok;
      vec_t tvec;

      vecs[0] = '{a: 32'h3f800000, b: 32'h3f800000, op: 2'd0, exp_q: 32'h3f800000, exp_err: 1'b0};
      vecs[1] = '{a: 32'h40490fdb, b: 32'h402df854, op: 2'd1, exp_q: 32'h3f93eee0, exp_err: 1'b0};
      vecs[2] = '{a: 32'h402df854, b: 32'h40490fdb, op: 2'd2, exp_q: 32'h3f5d816a, exp_err: 1'b0};
      vecs[3] = '{a: 32'h3f800000, b: 32'h3f000000, op: 2'd3, exp_q: 32'h40000000, exp_err: 1'b0};
      vecs[4] = '{a: 32'h3f800000, b: 32'h3f800000, op: 2'd1, exp_q: 32'h3f800000, exp_err: 1'b0};

      bus.req_valid = 1'b0;
      bus.req_a     = 32'h0;
      bus.req_b     = 32'h0;
      bus.req_op    = 2'd0;
      bus.res_ready = 1'b0;

      // Asynchronous reset, checked before any clock edge.
      #1 rst_n = 1'b0;
      #2;
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_dispatch", 32'(bus.dispatch), 32'd0);
      checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("rst_res_err", 32'(bus.res_err), 32'd0);
      checkOutput("rst_a", bus.a, 32'h0);
      checkOutput("rst_b", bus.b, 32'h0);
      checkOutput("rst_op", 32'(bus.op), 32'd0);
      checkOutput("rst_res_q", bus.res_q, 32'h0);
      checkOutput("rst_res_op", 32'(bus.res_op), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Done held high while idle must not produce a result.
      manual_q    = 32'hdeadbeef;
      manual_done = 1'b1;
      @(negedge clk);
      checkOutput("req_ready_after_reset", 32'(bus.req_ready), 32'd1);
      ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.res_valid) ok = 1'b0;
      end
      checkOutput("idle_done_ignored", 32'(ok), 32'd1);
      checkOutput("idle_no_dispatch", disp_count, 32'd0);
      @(posedge clk);
      #1;
      manual_done = 1'b0;
      unit_manual = 1'b0;

      // Single operation 1.0/1.0, result left waiting in the register.
      applyStimulus(vecs[0]);
      waitSignal("single_result_valid", 1, 30, t_res);
      checkOutput("single_res_q", bus.res_q, 32'h3f800000);
      checkOutput("single_res_err", 32'(bus.res_err), 32'd0);
      checkOutput("single_dispatch_count", disp_count, 32'd1);

      // Four back-to-back requests fill the queue behind the pending result.
      for (int i = 1; i <= 4; i++) applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput("fifo_full_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      waitDrain("burst_drain", 80);
      checkOutput("burst_dispatch_count", disp_count, 32'd5);

      // Back-pressure: only one issue while the result is not taken.
      bus.res_ready = 1'b0;
      d0 = disp_count;
      applyStimulus(vecs[1]);
      applyStimulus(vecs[2]);
      ok = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (bus.res_valid && (bus.res_q !== 32'h3f93eee0 || bus.res_op !== 2'd1)) ok = 1'b0;
      end
      checkOutput("hold_res_stable", 32'(ok), 32'd1);
      checkOutput("hold_res_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("hold_one_dispatch", disp_count - d0, 32'd1);
      @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      waitDrain("hold_drain", 60);
      checkOutput("hold_two_dispatches", disp_count - d0, 32'd2);

      // Reset in the middle of a wait, then a stray done after release.
      unit_manual = 1'b1;
      manual_done = 1'b0;
      applyStimulus(vecs[3]);
      waitSignal("abort_dispatch_seen", 0, 20, t_disp);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      checkOutput("abort_res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("abort_req_ready_low", 32'(bus.req_ready), 32'd0);
      checkOutput("abort_dispatch_low", 32'(bus.dispatch), 32'd0);
      res_sb.delete();
      iss_q.delete();
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      d0          = disp_count;
      manual_q    = 32'h12345678;
      manual_done = 1'b1;
      @(negedge clk);
      checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd1);
      ok = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (bus.res_valid || bus.dispatch) ok = 1'b0;
      end
      checkOutput("stray_done_ignored", 32'(ok), 32'd1);
      checkOutput("abort_no_dispatch", disp_count - d0, 32'd0);
      @(posedge clk);
      #1;
      manual_done = 1'b0;

`ifdef FPU_ISSUE_TIMEOUT_EN
      // Unit never answers: watchdog completes after 8 wait cycles with NaN.
      tvec = '{a: 32'h3f800000, b: 32'h3f000000, op: 2'd2, exp_q: 32'h7fc00000, exp_err: 1'b1};
      applyStimulus(tvec);
      applyStimulus(vecs[3]);
      waitSignal("timeout_dispatch", 0, 20, t_disp);
      waitSignal("timeout_result", 1, 30, t_res);
      checkOutput("timeout_latency", t_res - t_disp, 32'd9);
      unit_manual = 1'b0;
      waitDrain("timeout_drain", 40);
`else
      // Without the watchdog the wait lasts until done finally arrives.
      tvec = '{a: 32'h40400000, b: 32'h40000000, op: 2'd2, exp_q: 32'h55aa55aa, exp_err: 1'b0};
      applyStimulus(tvec);
      ok = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (bus.res_valid) ok = 1'b0;
      end
      checkOutput("wait_persists_without_done", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      manual_q    = 32'h55aa55aa;
      manual_done = 1'b1;
      @(posedge clk);
      #1;
      manual_done = 1'b0;
      waitDrain("late_done_drain", 20);
`endif

      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
